// File: rtl/module_decodi_secded.sv
// -----------------------------------------------------------------------------
// module_decodi_secded
// Receive-side decoder for the 8-bit extended Hamming(7,4) SECDED word.
// Word layout: [0]=p1 [1]=p2 [2]=d1 [3]=p3 [4]=d2 [5]=d3 [6]=d4 [7]=global parity.
// Two-stage valid/ready pipeline:
//   stage 1 registers the received word,
//   stage 2 registers the classified/corrected result.
// Single-bit errors are corrected and double-bit errors are flagged.
// Two saturating counters record how many errors of each kind were seen.
//
// Optional build macro:
//   DECODI_DROP_DED_EN  double-error words are consumed in stage 2 without ever
//                       raising out_valid; cnt_double counts them as they drop.
//
// Parameters:
//   CNT_W       width of each saturating error counter
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    datos_cod is valid
//   in_ready    stage 1 can take a word this cycle (combinational from out_ready)
//   datos_cod   received SECDED word
//   out_valid   decoded result is valid
//   out_ready   downstream accepts the result
//   datos_dec   corrected data {d4,d3,d2,d1}
//   sindrome    syndrome {c2,c1,c0} of the received word
//   err_single  single-bit error detected and corrected
//   err_double  double-bit error detected; data is left uncorrected
//   clr_cnt     synchronous clear of both counters; wins over a same-cycle increment
//   cnt_single  saturating count of single-bit errors
//   cnt_double  saturating count of double-bit errors
// -----------------------------------------------------------------------------
module module_decodi_secded #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       datos_cod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       datos_dec,
    output logic [2:0]       sindrome,
    output logic             err_single,
    output logic             err_double,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    // Stage-1 holding register
    logic       s1_valid;
    logic [7:0] s1_word;

    // Handshake / flow control
    logic s2_free;
    logic s1_adv;
    logic in_fire;
    logic out_fire;
    logic s2_load;
    logic inc_single;
    logic inc_double;

    // Decode of the stage-1 word
    logic [2:0] syn;
    logic       par;
    logic [7:0] fixed;
    logic [3:0] dec_data;
    logic       dec_single;
    logic       dec_double;

    // A stage advances when the stage after it is empty or draining this cycle.
    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        fixed      = s1_word;
        dec_single = 1'b0;
        dec_double = 1'b0;

        syn[0] = s1_word[0] ^ s1_word[2] ^ s1_word[4] ^ s1_word[6];
        syn[1] = s1_word[1] ^ s1_word[2] ^ s1_word[5] ^ s1_word[6];
        syn[2] = s1_word[3] ^ s1_word[4] ^ s1_word[5] ^ s1_word[6];
        par    = ^s1_word;

        if (par) begin
            // Odd overall parity means exactly one bit flipped.
            // A zero syndrome places that bit on b7, which carries no data.
            dec_single = 1'b1;
            if (syn != 3'd0) begin
                fixed[syn - 3'd1] = ~s1_word[syn - 3'd1];
            end
        end else if (syn != 3'd0) begin
            // Even parity with a non-zero syndrome means two bits flipped,
            // which cannot be corrected.
            dec_double = 1'b1;
        end

        dec_data = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

`ifdef DECODI_DROP_DED_EN
    // A double-error word leaves stage 1 but never occupies the output slot.
    assign s2_load    = s1_adv && !dec_double;
    assign inc_double = s1_adv && dec_double;
`else
    assign s2_load    = s1_adv;
    assign inc_double = out_fire && err_double;
`endif
    assign inc_single = out_fire && err_single;

    // Stage 1: capture the received word.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value regardless of the order of the statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_word  <= 8'h00;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_word  <= datos_cod;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register.
    // Its outputs stay frozen while downstream stalls.
    // NOTE: the result registers are reset as well as the valids, because zeroed
    // outputs after reset are part of the visible interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            datos_dec  <= 4'h0;
            sindrome   <= 3'd0;
            err_single <= 1'b0;
            err_double <= 1'b0;
        end else if (s2_load) begin
            out_valid  <= 1'b1;
            datos_dec  <= dec_data;
            sindrome   <= syn;
            err_single <= dec_single;
            err_double <= dec_double;
        end else if (out_fire) begin
            out_valid  <= 1'b0;
        end
    end

    // Saturating error counters; clr_cnt has priority over any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else if (clr_cnt) begin
            cnt_single <= '0;
            cnt_double <= '0;
        end else begin
            if (inc_single && (cnt_single != '1)) begin
                cnt_single <= cnt_single + 1'b1;
            end
            if (inc_double && (cnt_double != '1)) begin
                cnt_double <= cnt_double + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_module_decodi_secded.sv
`timescale 1ns/1ps
module tb_module_decodi_secded;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       datos_cod;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       datos_dec;
    logic [2:0]       sindrome;
    logic             err_single;
    logic             err_double;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_double;

    int n_checks = 0;
    int n_errors = 0;

    module_decodi_secded #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .datos_cod  (datos_cod),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .datos_dec  (datos_dec),
        .sindrome   (sindrome),
        .err_single (err_single),
        .err_double (err_double),
        .clr_cnt    (clr_cnt),
        .cnt_single (cnt_single),
        .cnt_double (cnt_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [2:0] s;
        logic       es;
        logic       ed;
    } res_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference decoder: the syndrome is the XOR of the Hamming positions (1..7)
    // of all set bits b0..b6, and the overall parity is a population count.
    function automatic res_t decode_model(input logic [7:0] w);
        res_t       r;
        int         syn;
        int         ones;
        logic [7:0] c;
        syn  = 0;
        c    = w;
        ones = $countones(w);
        for (int i = 0; i < 7; i++) if (w[i]) syn = syn ^ (i + 1);
        r.s  = syn[2:0];
        r.es = 1'b0;
        r.ed = 1'b0;
        if (ones % 2 == 1) begin
            r.es = 1'b1;
            if (syn != 0) c[syn - 1] = ~c[syn - 1];
        end else if (syn != 0) begin
            r.ed = 1'b1;
        end
        r.d = {c[6], c[5], c[4], c[2]};
        return r;
    endfunction

    // Encoder: data goes to positions 3,5,6,7. Each parity bit at position 1, 2
    // or 4 cancels its share of the data syndrome. b7 makes the total parity even.
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] w;
        int         syn;
        w    = 8'h00;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        syn  = 0;
        for (int i = 0; i < 7; i++) if (w[i]) syn = syn ^ (i + 1);
        w[0] = syn[0];
        w[1] = syn[1];
        w[3] = syn[2];
        w[7] = ^w[6:0];
        return w;
    endfunction

    function automatic logic [7:0] single_err(input logic [3:0] d);
        logic [7:0] w;
        w = encode(d);
        w[$urandom_range(0, 7)] ^= 1'b1;
        return w;
    endfunction

    function automatic logic [7:0] double_err(input logic [3:0] d);
        logic [7:0] w;
        int         a;
        int         b;
        w = encode(d);
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        w[a] ^= 1'b1;
        w[b] ^= 1'b1;
        return w;
    endfunction

    function automatic logic [7:0] rand_word();
        logic [3:0] d;
        d = 4'($urandom);
        case ($urandom_range(0, 3))
            0:       return encode(d);
            1:       return single_err(d);
            2:       return double_err(d);
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic int sat(input int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    // ---------------- scoreboard / monitor (negedge sampling) ----------------
    res_t       exp_q[$];
    int         m_cnt_s;
    int         m_cnt_d;
    logic       prev_stall;
    logic [8:0] prev_bundle;

    always @(negedge clk) begin
        res_t e;
        bit   popped;
        popped = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt_s    = 0;
            m_cnt_d    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {datos_dec, sindrome, err_single, err_double}, prev_bundle);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    popped = 1'b1;
                    check("out_data", datos_dec, e.d);
                    check("out_syn", sindrome, e.s);
                    check("out_err_single", err_single, e.es);
                    check("out_err_double", err_double, e.ed);
                end
            end
            check("cnt_single", cnt_single, m_cnt_s);
`ifndef DECODI_DROP_DED_EN
            check("cnt_double", cnt_double, m_cnt_d);
`endif
            if (clr_cnt) begin
                m_cnt_s = 0;
                m_cnt_d = 0;
            end else if (popped) begin
                if (e.es) m_cnt_s = sat(m_cnt_s);
                if (e.ed) m_cnt_d = sat(m_cnt_d);
            end
            if (in_valid && in_ready) begin
                e = decode_model(datos_cod);
`ifdef DECODI_DROP_DED_EN
                if (e.ed) m_cnt_d = sat(m_cnt_d);
                else      exp_q.push_back(e);
`else
                exp_q.push_back(e);
`endif
            end
            prev_stall  = out_valid && !out_ready;
            prev_bundle = {datos_dec, sindrome, err_single, err_double};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] w);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        datos_cod = w;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic directed(input string tag, input logic [7:0] w, input logic [3:0] d,
                            input logic [2:0] s, input logic es, input logic ed);
        bit seen;
        seen = 1'b0;
        send(w);
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({tag, "_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_data"}, datos_dec, d);
            check({tag, "_syn"}, sindrome, s);
            check({tag, "_single"}, err_single, es);
            check({tag, "_double"}, err_double, ed);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_datos_dec"}, datos_dec, 0);
        check({tag, "_sindrome"}, sindrome, 0);
        check({tag, "_err_single"}, err_single, 0);
        check({tag, "_err_double"}, err_double, 0);
        check({tag, "_cnt_single"}, cnt_single, 0);
        check({tag, "_cnt_double"}, cnt_double, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit hs;
        bit seen;
        bit drained;
        int acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        datos_cod = 8'h00;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        #12;
        check_reset("rst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Spec examples
        directed("ex1", 8'h55, 4'hB, 3'd0, 1'b0, 1'b0);
        directed("ex2", 8'h45, 4'hB, 3'd5, 1'b1, 1'b0);
        check("ex2_cnt_single", cnt_single, 1);
        directed("ex3", 8'hD5, 4'hB, 3'd0, 1'b1, 1'b0);
        check("ex3_cnt_single", cnt_single, 2);
`ifdef DECODI_DROP_DED_EN
        send(8'h56);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("ex4_dropped", seen, 0);
        @(posedge clk);
        #1;
`else
        directed("ex4", 8'h56, 4'hB, 3'd3, 1'b0, 1'b1);
`endif
        check("ex4_cnt_double", cnt_double, 1);

        // Back-to-back words with out_ready held low for three edges
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        datos_cod = encode(4'($urandom));
        acc = 0;
        repeat (3) begin
            @(negedge clk);
            hs = in_ready;
            if (hs) acc++;
            @(posedge clk);
            #1;
            if (hs) datos_cod = encode(4'($urandom));
        end
        check("stall_accepted", acc, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) datos_cod = encode(4'($urandom));
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_drained", exp_q.size(), 0);

        // Saturation and clear priority
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_cnt_single", cnt_single, 0);
        check("clr_cnt_double", cnt_double, 0);
        repeat (5) send(single_err(4'($urandom)));
        repeat (4) @(posedge clk);
        #1;
        check("sat_single", cnt_single, CMAX);
        out_ready = 1'b0;
        send(single_err(4'($urandom)));
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("clr_word_held", seen, 1);
        clr_cnt   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        check("clr_priority", cnt_single, 0);

        // Randomized traffic with a mid-stream reset
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                #2 rst_n = 1'b0;
                #1;
                check_reset("mid_rst");
                in_valid = 1'b0;
                clr_cnt  = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || hs) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                datos_cod = rand_word();
            end
            out_ready = ($urandom_range(0, 9) < 7);
`ifndef DECODI_DROP_DED_EN
            clr_cnt = ($urandom_range(0, 49) == 0);
`endif
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        drained   = 1'b0;
        for (int i = 0; i < 50 && !drained; i++) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) drained = 1'b1;
        end
        check("final_drain", drained, 1);
        @(posedge clk);
        #1;
`ifdef DECODI_DROP_DED_EN
        check("final_cnt_double", cnt_double, m_cnt_d);
`endif
        check("final_cnt_single", cnt_single, m_cnt_s);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
